// File: rtl/udma_eth_pkg.sv
// Shared types for the uDMA Ethernet TX scheduler: FSM states, error codes, descriptor layout.
// Pure declarations, no logic; backpressure n/a.
package udma_eth_pkg;

    localparam int L2_AWIDTH_NOAL_DEF = 12;
    localparam int TRANS_SIZE_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PROGRAM   = 2'd1,
        WAIT_EN   = 2'd2,
        WAIT_DONE = 2'd3
    } tx_sched_state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_LEN   = 2'd1,
        ERR_EN_TMO    = 2'd2,
        ERR_SPUR_DONE = 2'd3
    } tx_err_e;

    typedef struct packed {
        logic [L2_AWIDTH_NOAL_DEF-1:0] addr;
        logic [TRANS_SIZE_DEF-1:0]     len;
    } tx_desc_t;

endpackage

// File: rtl/udma_eth_desc_fifo.sv
// Sync FIFO of TX descriptors, show-ahead head; push/pop take effect at the clock edge, flush beats both.
// Backpressure: caller must not push while o_full; pop on empty is ignored.
module udma_eth_desc_fifo
    import udma_eth_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  tx_desc_t                 i_push_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output tx_desc_t                 o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    tx_desc_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

endmodule

// File: rtl/udma_eth_tx_sched.sv
// Sequences the uDMA TX channel one descriptor at a time; push into idle empty queue -> cfg_tx_en_o 2 cycles later.
// Backpressure: desc_ready_o low while queue full, during abort and during reset.
module udma_eth_tx_sched
    import udma_eth_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = L2_AWIDTH_NOAL_DEF,
    parameter int TRANS_SIZE     = TRANS_SIZE_DEF,
    parameter int DESC_DEPTH     = 4,
    parameter int MIN_FRAME      = 60,
    parameter int MAX_FRAME      = 1514,
    parameter int EN_TIMEOUT     = 255
) (
    input  logic                          sys_clk_i,
    input  logic                          rst_i,
    input  logic                          desc_valid_i,
    output logic                          desc_ready_o,
    input  logic [L2_AWIDTH_NOAL-1:0]     desc_addr_i,
    input  logic [TRANS_SIZE-1:0]         desc_len_i,
    input  logic                          abort_i,
    input  logic                          frame_done_i,
    input  logic                          cfg_tx_en_i,
    output logic [L2_AWIDTH_NOAL-1:0]     cfg_tx_startaddr_o,
    output logic [TRANS_SIZE-1:0]         cfg_tx_size_o,
    output logic                          cfg_tx_continuous_o,
    output logic                          cfg_tx_en_o,
    output logic                          cfg_tx_clr_o,
    output logic                          busy_o,
    output logic [$clog2(DESC_DEPTH):0]   level_o,
    output logic                          done_evt_o,
    output logic                          err_evt_o,
    output logic [1:0]                    err_code_o,
    output logic [15:0]                   sent_cnt_o
);

    localparam int TW = $clog2(EN_TIMEOUT + 1);
    localparam logic [TW-1:0]         TMO_LAST = TW'(EN_TIMEOUT - 1);
    localparam logic [TRANS_SIZE-1:0] LEN_MIN  = TRANS_SIZE'(MIN_FRAME);
    localparam logic [TRANS_SIZE-1:0] LEN_MAX  = TRANS_SIZE'(MAX_FRAME);

    tx_sched_state_e             r_state;
    tx_sched_state_e             w_state_nxt;
    tx_desc_t                    w_head;
    tx_desc_t                    w_push_dat;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_push_hs;
    logic                        w_len_ok;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_start;
    logic                        w_tmo;
    logic                        w_done;
    logic                        w_spur;
    logic [TW-1:0]               r_tmo;
    logic [L2_AWIDTH_NOAL-1:0]   r_startaddr;
    logic [TRANS_SIZE-1:0]       r_size;
    logic                        r_clr;
    logic                        r_done_evt;
    logic                        r_err_evt;
    tx_err_e                     r_err_code;
    logic [15:0]                 r_sent_cnt;

    assign desc_ready_o = !rst_i && !w_full && !abort_i;
    assign w_push_hs    = desc_valid_i && desc_ready_o;
    assign w_len_ok     = (desc_len_i >= LEN_MIN) && (desc_len_i <= LEN_MAX);
    // Out-of-range lengths are handshaken away but never enter the queue.
    assign w_push       = w_push_hs && w_len_ok;
    assign w_push_dat   = '{addr: desc_addr_i, len: desc_len_i};

    udma_eth_desc_fifo #(
        .DEPTH      (DESC_DEPTH)
    ) u_desc_fifo (
        .i_clk      (sys_clk_i),
        .i_rst      (rst_i),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (abort_i),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (level_o)
    );

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_start     = 1'b0;
        w_tmo       = 1'b0;
        w_done      = 1'b0;
        w_spur      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_start     = 1'b1;
                    w_state_nxt = PROGRAM;
                end
            end
            PROGRAM: begin
                w_pop       = 1'b1;
                w_state_nxt = WAIT_EN;
            end
            WAIT_EN: begin
                if (cfg_tx_en_i) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_tmo == TMO_LAST) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (frame_done_i) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (frame_done_i && (r_state != WAIT_DONE)) begin
            w_spur = 1'b1;
        end
        if (abort_i) begin
            w_state_nxt = IDLE;
            w_start     = 1'b0;
            w_tmo       = 1'b0;
            w_done      = 1'b0;
            w_spur      = 1'b0;
        end
    end

    // Address/size are latched on entry to PROGRAM so they are valid alongside the enable pulse.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            r_startaddr <= '0;
            r_size      <= '0;
            r_tmo       <= '0;
            r_clr       <= 1'b0;
            r_done_evt  <= 1'b0;
            r_err_evt   <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_sent_cnt  <= '0;
        end else begin
            if (w_start) begin
                r_startaddr <= w_head.addr;
                r_size      <= w_head.len;
            end
            r_tmo      <= (r_state == WAIT_EN) ? r_tmo + 1'b1 : '0;
            r_clr      <= abort_i || w_tmo;
            r_done_evt <= w_done;
            if (w_done) begin
                r_sent_cnt <= r_sent_cnt + 16'd1;
            end
            r_err_evt <= w_tmo || w_spur || (w_push_hs && !w_len_ok);
            if (w_tmo) begin
                r_err_code <= ERR_EN_TMO;
            end else if (w_spur) begin
                r_err_code <= ERR_SPUR_DONE;
            end else if (w_push_hs && !w_len_ok) begin
                r_err_code <= ERR_BAD_LEN;
            end else begin
                r_err_code <= ERR_NONE;
            end
        end
    end

    assign cfg_tx_startaddr_o  = r_startaddr;
    assign cfg_tx_size_o       = r_size;
    assign cfg_tx_continuous_o = 1'b0;
    assign cfg_tx_en_o         = (r_state == PROGRAM);
    assign cfg_tx_clr_o        = r_clr;
    assign busy_o              = (r_state != IDLE);
    assign done_evt_o          = r_done_evt;
    assign err_evt_o           = r_err_evt;
    assign err_code_o          = r_err_code;
    assign sent_cnt_o          = r_sent_cnt;

endmodule

// File: tb/tb_udma_eth_tx_sched.sv
// Randomized bench for udma_eth_tx_sched: queue-based descriptor model plus per-scenario event expectations.
`timescale 1ns/1ps
module tb_udma_eth_tx_sched;

    localparam int DEPTH = 4;
    localparam int MINF  = 60;
    localparam int MAXF  = 1514;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] len;
    } mdesc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        desc_valid;
    logic        desc_ready;
    logic [11:0] desc_addr;
    logic [15:0] desc_len;
    logic        abort;
    logic        frame_done;
    logic        tx_en_in;
    logic [11:0] startaddr;
    logic [15:0] size;
    logic        cont;
    logic        tx_en_out;
    logic        tx_clr;
    logic        busy;
    logic [2:0]  level;
    logic        done_evt;
    logic        err_evt;
    logic [1:0]  err_code;
    logic [15:0] sent_cnt;

    int          n_total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          en_seen = 0;
    int          last_en_cyc = 0;
    int          done_seen = 0;
    int          served = 0;
    int          exp_bad_len = 0;
    logic [15:0] exp_sent = 16'd0;
    mdesc_t      exp_q[$];
    logic [1:0]  err_q[$];
    mdesc_t      mon_d;

    udma_eth_tx_sched dut (
        .sys_clk_i           (clk),
        .rst_i               (rst),
        .desc_valid_i        (desc_valid),
        .desc_ready_o        (desc_ready),
        .desc_addr_i         (desc_addr),
        .desc_len_i          (desc_len),
        .abort_i             (abort),
        .frame_done_i        (frame_done),
        .cfg_tx_en_i         (tx_en_in),
        .cfg_tx_startaddr_o  (startaddr),
        .cfg_tx_size_o       (size),
        .cfg_tx_continuous_o (cont),
        .cfg_tx_en_o         (tx_en_out),
        .cfg_tx_clr_o        (tx_clr),
        .busy_o              (busy),
        .level_o             (level),
        .done_evt_o          (done_evt),
        .err_evt_o           (err_evt),
        .err_code_o          (err_code),
        .sent_cnt_o          (sent_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit len_ok(input logic [15:0] l);
        return (l >= MINF) && (l <= MAXF);
    endfunction

    // Every enable pulse must program the oldest still-queued descriptor.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_en_out) begin
                en_seen++;
                last_en_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("en_unexpected", 1, 0);
                end else begin
                    mon_d = exp_q.pop_front();
                    chk("startaddr", startaddr, mon_d.addr);
                    chk("size", size, mon_d.len);
                end
            end
            if (done_evt) done_seen++;
            if (err_evt) err_q.push_back(err_code);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] a, input logic [15:0] l);
        bit     exp_rdy;
        mdesc_t d;
        exp_rdy = (exp_q.size() < DEPTH);
        desc_valid = 1'b1;
        desc_addr  = a;
        desc_len   = l;
        #1;
        chk("desc_ready", desc_ready, exp_rdy);
        chk("level", level, exp_q.size());
        if (exp_rdy) begin
            if (len_ok(l)) begin
                d.addr = a;
                d.len  = l;
                exp_q.push_back(d);
            end else begin
                exp_bad_len++;
            end
        end
        step();
        desc_valid = 1'b0;
    endtask

    task automatic wait_en_count(input int target);
        for (int i = 0; i < 400 && en_seen < target; i++) step();
        chk("en_wait", en_seen >= target, 1);
    endtask

    task automatic finish_frame(input int d_en, input int d_done);
        repeat (d_en) step();
        tx_en_in = 1'b1;
        repeat (2 + d_done) step();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        tx_en_in   = 1'b0;
        exp_sent++;
        chk("done_evt", done_evt, 1);
        chk("sent_cnt", sent_cnt, exp_sent);
    endtask

    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            served++;
            wait_en_count(served);
            finish_frame($urandom_range(0, 3), $urandom_range(0, 4));
        end
    endtask

    task automatic check_errs(input string tag, input int n, input logic [1:0] code);
        chk({tag, "_err_cnt"}, err_q.size(), n);
        foreach (err_q[i]) chk({tag, "_err_code"}, err_q[i], code);
        err_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  en_before;
        int  delta;
        bit  got_err;

        rst = 1'b1; desc_valid = 1'b0; desc_addr = '0; desc_len = '0;
        abort = 1'b0; frame_done = 1'b0; tx_en_in = 1'b0;
        repeat (3) step();
        chk("rst_ready", desc_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_en", tx_en_out, 0);
        chk("rst_clr", tx_clr, 0);
        chk("rst_done", done_evt, 0);
        chk("rst_err", err_evt, 0);
        chk("rst_sent", sent_cnt, 0);
        chk("rst_addr", startaddr, 0);
        chk("rst_size", size, 0);
        chk("rst_cont", cont, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", desc_ready, 1);
        step();

        // single frame latency
        push(12'h100, 16'd64);
        chk("lat_en_c1", tx_en_out, 0);
        chk("lat_level", level, 1);
        step();
        chk("lat_en_c2", tx_en_out, 1);
        chk("lat_addr", startaddr, 12'h100);
        chk("lat_size", size, 16'd64);
        chk("lat_busy", busy, 1);
        served = 1;
        finish_frame(1, 2);
        check_errs("t1", 0, 0);

        // fill the queue while the channel is busy
        push(12'h200, 16'd100);
        served++;
        wait_en_count(served);
        for (int i = 0; i < 4; i++) push(12'h210 + 12'(i), 16'd200 + 16'(i));
        push(12'h2ff, 16'd300);
        chk("fill_level", level, 4);
        finish_frame(0, 1);
        serve(4);
        chk("fill_sent", sent_cnt, 16'd6);
        check_errs("fill", 0, 0);

        // length boundaries
        en_before   = en_seen;
        exp_bad_len = 0;
        push(12'h300, 16'd59);
        push(12'h301, 16'd1515);
        repeat (3) step();
        check_errs("badlen", 2, 1);
        chk("badlen_level", level, 0);
        chk("badlen_no_en", en_seen, en_before);
        chk("badlen_busy", busy, 0);
        push(12'h310, 16'd60);
        push(12'h311, 16'd1514);
        serve(2);
        check_errs("bound", 0, 0);

        // enable timeout drops the head and moves on
        push(12'h400, 16'd200);
        push(12'h401, 16'd300);
        served++;
        got_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (err_evt) begin
                got_err = 1'b1;
                break;
            end
        end
        delta = cyc - last_en_cyc;
        chk("tmo_seen", got_err, 1);
        chk("tmo_code", err_code, 2);
        chk("tmo_clr", tx_clr, 1);
        chk("tmo_window", (delta >= 255) && (delta <= 257), 1);
        chk("tmo_busy", busy, 0);
        served++;
        wait_en_count(served);
        finish_frame(1, 1);
        check_errs("tmo", 1, 2);

        // abort while waiting for the frame with three queued
        push(12'h500, 16'd500);
        served++;
        wait_en_count(served);
        tx_en_in = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) push(12'h510 + 12'(i), 16'd80);
        chk("abort_lvl_pre", level, 3);
        abort = 1'b1;
        #1;
        chk("abort_ready", desc_ready, 0);
        step();
        abort = 1'b0;
        tx_en_in = 1'b0;
        exp_q.delete();
        chk("abort_clr", tx_clr, 1);
        chk("abort_level", level, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done_evt, 0);
        en_before = en_seen;
        repeat (10) step();
        chk("abort_no_en", en_seen, en_before);
        chk("abort_done_cnt", done_seen, exp_sent);
        chk("abort_sent", sent_cnt, exp_sent);
        chk("abort_clr_once", tx_clr, 0);
        check_errs("abort", 0, 0);

        // done pulse with nothing in flight
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        repeat (2) step();
        check_errs("spur", 1, 3);
        chk("spur_sent", sent_cnt, exp_sent);
        chk("spur_busy", busy, 0);

        // random descriptor bursts
        for (int r = 0; r < 15; r++) begin
            int          k;
            int          ng;
            logic [11:0] a;
            logic [15:0] l;
            ng = 0;
            exp_bad_len = 0;
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                a = 12'($urandom);
                if ($urandom_range(0, 3) == 0)
                    l = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 59))
                                                    : 16'($urandom_range(1515, 4000));
                else
                    l = 16'($urandom_range(60, 1514));
                if (len_ok(l) && exp_q.size() < DEPTH) ng++;
                push(a, l);
                repeat ($urandom_range(0, 2)) step();
            end
            serve(ng);
            repeat (2) step();
            check_errs("rnd", exp_bad_len, 1);
            chk("rnd_level", level, 0);
        end

        chk("done_total", done_seen, exp_sent);
        chk("q_empty", exp_q.size(), 0);
        chk("cont_end", cont, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
